// File: rtl/rsv_pkg.sv
// Shared types and constants for dispatch and the reservation station.
// Holds widths, the idle micro-op, the dispatch-entry struct and a CDB match helper.
package rsv_pkg;

  localparam int W_PA_REG   = 5;
  localparam int N_REG      = 32;
  localparam int W_PD_DATA  = 32;
  localparam int W_AA_INSTR = 32;
  localparam int W_PD_UOPS  = 6;
  localparam int W_PD_req   = 2;

  localparam logic [W_PD_UOPS-1:0] unused_op = '1;

  typedef struct packed {
    logic [W_PD_req-1:0]   req;
    logic [W_PD_UOPS-1:0]  uops;
    logic [W_PA_REG-1:0]   rd;
    logic                  rs_v;
    logic [W_PA_REG-1:0]   rs_a;
    logic [W_PD_DATA-1:0]  rs_d;
    logic                  rt_v;
    logic [W_PA_REG-1:0]   rt_a;
    logic [W_PD_DATA-1:0]  rt_d;
    logic [W_PD_DATA-1:0]  imm;
    logic [W_AA_INSTR-1:0] pc;
  } rsv_entry_t;

  localparam rsv_entry_t ENTRY_RST = '{uops: unused_op, default: '0};

  // Register 0 never matches: it is hardwired and never broadcast.
  function automatic logic cdb_hit(
    input logic                v,
    input logic [W_PA_REG-1:0] ca,
    input logic [W_PA_REG-1:0] a
  );
    return v && (ca == a) && (a != '0);
  endfunction

endpackage

// File: rtl/reg_busy_table.sv
// Busy-bit scoreboard: one bit per architectural register, set on dispatch,
// cleared by CDB broadcast. Ports: set/clear, rs/rt/rd lookups with CDB hit flags.
module reg_busy_table
  import rsv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                set_i,
  input  logic [W_PA_REG-1:0] set_a_i,
  input  logic                upt_v_i,
  input  logic [W_PA_REG-1:0] upt_a_i,
  input  logic [W_PA_REG-1:0] rs_a_i,
  input  logic [W_PA_REG-1:0] rt_a_i,
  input  logic [W_PA_REG-1:0] rd_a_i,
  output logic                rs_busy_o,
  output logic                rt_busy_o,
  output logic                rd_busy_o,
  output logic                rs_hit_o,
  output logic                rt_hit_o,
  output logic                rd_hit_o
);

  logic [N_REG-1:0] busy_q;
  logic [N_REG-1:0] busy_d;

  assign rs_busy_o = busy_q[rs_a_i];
  assign rt_busy_o = busy_q[rt_a_i];
  assign rd_busy_o = busy_q[rd_a_i];
  assign rs_hit_o  = cdb_hit(upt_v_i, upt_a_i, rs_a_i);
  assign rt_hit_o  = cdb_hit(upt_v_i, upt_a_i, rt_a_i);
  assign rd_hit_o  = cdb_hit(upt_v_i, upt_a_i, rd_a_i);

  // Clear first so a same-cycle set of that register wins.
  always_comb begin
    busy_d = busy_q;
    if (upt_v_i && upt_a_i != '0)
      busy_d[upt_a_i] = 1'b0;
    if (set_i && set_a_i != '0)
      busy_d[set_a_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_i || clr_i)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

endmodule

// File: rtl/rsv_dispatch.sv
// Dispatch stage in front of the reservation station: reads operands, tags readiness,
// bypasses the CDB and holds one registered entry while the station is full.
module rsv_dispatch
  import rsv_pkg::*;
(
  input  logic                  clk,
  input  logic                  CFI_PC_rst,
  input  logic                  CFI_PC_clear,
  input  logic                  DFI_PV_inst,
  input  logic [W_PD_req-1:0]   DFI_PD_REQ,
  input  logic [W_PD_UOPS-1:0]  DFI_PD_uops,
  input  logic [W_PA_REG-1:0]   DFI_PA_rd,
  input  logic [W_PA_REG-1:0]   DFI_PA_rs,
  input  logic [W_PA_REG-1:0]   DFI_PA_rt,
  input  logic                  DFI_PV_wrd,
  input  logic                  DFI_PV_urs,
  input  logic                  DFI_PV_urt,
  input  logic [W_PD_DATA-1:0]  DFI_PD_imm,
  input  logic [W_AA_INSTR-1:0] DFI_AA_pc,
  output logic [W_PA_REG-1:0]   CDO_PA_rf1,
  output logic [W_PA_REG-1:0]   CDO_PA_rf2,
  input  logic [W_PD_DATA-1:0]  CDI_PD_rf1,
  input  logic [W_PD_DATA-1:0]  CDI_PD_rf2,
  input  logic                  CDI_PV_upt1,
  input  logic [W_PA_REG-1:0]   CDI_PA_upt1,
  input  logic [W_PD_DATA-1:0]  CDI_PD_upt1,
  input  logic                  CFI_PC_full,
  output logic                  CFO_PC_stall,
  output logic                  DFO_PV_ena,
  output logic [W_PD_req-1:0]   DFO_PD_REQ,
  output logic [W_PD_UOPS-1:0]  DFO_PD_uops,
  output logic [W_PA_REG-1:0]   DFO_PA_rd,
  output logic                  DFO_PV_rs,
  output logic [W_PA_REG-1:0]   DFO_PA_rs,
  output logic [W_PD_DATA-1:0]  DFO_PD_rs,
  output logic                  DFO_PV_rt,
  output logic [W_PA_REG-1:0]   DFO_PA_rt,
  output logic [W_PD_DATA-1:0]  DFO_PD_rt,
  output logic [W_PD_DATA-1:0]  DFO_PD_imm,
  output logic [W_AA_INSTR-1:0] DFO_AA_pc
);

  rsv_entry_t ent_q, ent_d, ent_in;
  logic       ena_q, ena_d;
  logic       fire, room, hazard, acc;
  logic       rs_busy, rt_busy, rd_busy;
  logic       rs_hit, rt_hit, rd_hit;

  assign CDO_PA_rf1 = DFI_PA_rs;
  assign CDO_PA_rf2 = DFI_PA_rt;

  reg_busy_table u_busy (
    .clk       (clk),
    .rst_i     (CFI_PC_rst),
    .clr_i     (CFI_PC_clear),
    .set_i     (acc && DFI_PV_wrd),
    .set_a_i   (DFI_PA_rd),
    .upt_v_i   (CDI_PV_upt1),
    .upt_a_i   (CDI_PA_upt1),
    .rs_a_i    (DFI_PA_rs),
    .rt_a_i    (DFI_PA_rt),
    .rd_a_i    (DFI_PA_rd),
    .rs_busy_o (rs_busy),
    .rt_busy_o (rt_busy),
    .rd_busy_o (rd_busy),
    .rs_hit_o  (rs_hit),
    .rt_hit_o  (rt_hit),
    .rd_hit_o  (rd_hit)
  );

  assign fire   = ena_q && !CFI_PC_full;
  assign room   = !ena_q || fire;
  assign hazard = DFI_PV_wrd && (DFI_PA_rd != '0)
                  && rd_busy && !rd_hit;
  assign acc    = DFI_PV_inst && room && !hazard
                  && !CFI_PC_clear;
  assign CFO_PC_stall = DFI_PV_inst && !acc;

  always_comb begin
    ent_in      = '0;
    ent_in.req  = DFI_PD_REQ;
    ent_in.uops = DFI_PD_uops;
    ent_in.rd   = DFI_PA_rd;
    ent_in.rs_a = DFI_PA_rs;
    ent_in.rt_a = DFI_PA_rt;
    ent_in.imm  = DFI_PD_imm;
    ent_in.pc   = DFI_AA_pc;
    ent_in.rs_v = 1'b1;
    ent_in.rt_v = 1'b1;
    if (DFI_PV_urs && DFI_PA_rs != '0) begin
      if (rs_hit)
        ent_in.rs_d = CDI_PD_upt1;
      else if (rs_busy)
        ent_in.rs_v = 1'b0;
      else
        ent_in.rs_d = CDI_PD_rf1;
    end
    if (DFI_PV_urt && DFI_PA_rt != '0) begin
      if (rt_hit)
        ent_in.rt_d = CDI_PD_upt1;
      else if (rt_busy)
        ent_in.rt_v = 1'b0;
      else
        ent_in.rt_d = CDI_PD_rf2;
    end
  end

  // A held entry keeps snooping the CDB so a wakeup is not lost while full.
  always_comb begin
    ena_d = ena_q;
    ent_d = ent_q;
    if (CFI_PC_clear) begin
      ena_d      = 1'b0;
      ent_d.uops = unused_op;
    end else if (acc) begin
      ena_d = 1'b1;
      ent_d = ent_in;
    end else if (fire) begin
      ena_d      = 1'b0;
      ent_d.uops = unused_op;
    end else begin
      if (!ent_q.rs_v && cdb_hit(CDI_PV_upt1, CDI_PA_upt1, ent_q.rs_a)) begin
        ent_d.rs_v = 1'b1;
        ent_d.rs_d = CDI_PD_upt1;
      end
      if (!ent_q.rt_v && cdb_hit(CDI_PV_upt1, CDI_PA_upt1, ent_q.rt_a)) begin
        ent_d.rt_v = 1'b1;
        ent_d.rt_d = CDI_PD_upt1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (CFI_PC_rst) begin
      ena_q <= 1'b0;
      ent_q <= ENTRY_RST;
    end else begin
      ena_q <= ena_d;
      ent_q <= ent_d;
    end
  end

  assign DFO_PV_ena  = ena_q;
  assign DFO_PD_REQ  = ent_q.req;
  assign DFO_PD_uops = ent_q.uops;
  assign DFO_PA_rd   = ent_q.rd;
  assign DFO_PV_rs   = ent_q.rs_v;
  assign DFO_PA_rs   = ent_q.rs_a;
  assign DFO_PD_rs   = ent_q.rs_d;
  assign DFO_PV_rt   = ent_q.rt_v;
  assign DFO_PA_rt   = ent_q.rt_a;
  assign DFO_PD_rt   = ent_q.rt_d;
  assign DFO_PD_imm  = ent_q.imm;
  assign DFO_AA_pc   = ent_q.pc;

endmodule
